map_table: RTL and testbench

Speculative rename map for the R10K pipeline. Each cycle it renames at most one instruction: it looks up source physical tags and their ready bits, pops a fresh destination tag from the free list, and reports the displaced tag (T_old) for the ROB. It also keeps an architectural (retirement) map that is updated at commit and copied into the speculative map on a flush. It sits between decode/dispatch and the free list, and snoops the CDB.

---
 rtl/map_table.sv | 134 +++++++++++++
 tb/tb_map_table.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/map_table.sv
// map_table: speculative rename map for an R10K-style pipeline.
// Renames at most one instruction per cycle. Each rename looks up the source
// physical tags and their ready bits, takes a fresh destination tag from the
// free list, and reports the displaced tag (t_old) for the ROB. An
// architectural map is updated at retire and copied into the speculative map
// on flush. The ready bit vector is set by the CDB and cleared by allocation.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   rn_valid / rn_ready     rename handshake
//   rs1_idx, rs2_idx        source architectural registers
//   rd_idx, rd_wr           destination architectural register and write flag
//   t1, t2, t1_ready, t2_ready   source physical tags and ready bits
//   t_new, t_old            allocated and displaced destination tags
//   fl_tag, fl_empty, fl_pop     free list top-of-stack, empty flag, pop
//   cdb_valid, cdb_tag      completion broadcast
//   rt_valid, rt_rd_idx, rt_t_new   retire update of the architectural map
//   flush                   mispredict recovery
module map_table #(
  parameter int unsigned ARCH_REGS = 32,
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned TAG_W     = $clog2(PHYS_REGS),
  parameter int unsigned IDX_W     = $clog2(ARCH_REGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rn_valid,
  output logic             rn_ready,
  input  logic [IDX_W-1:0] rs1_idx,
  input  logic [IDX_W-1:0] rs2_idx,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_wr,
  output logic [TAG_W-1:0] t1,
  output logic [TAG_W-1:0] t2,
  output logic             t1_ready,
  output logic             t2_ready,
  output logic [TAG_W-1:0] t_new,
  output logic [TAG_W-1:0] t_old,
  input  logic [TAG_W-1:0] fl_tag,
  input  logic             fl_empty,
  output logic             fl_pop,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             rt_valid,
  input  logic [IDX_W-1:0] rt_rd_idx,
  input  logic [TAG_W-1:0] rt_t_new,
  input  logic             flush
);

  logic [TAG_W-1:0]     smap     [ARCH_REGS];
  logic [TAG_W-1:0]     amap     [ARCH_REGS];
  logic [TAG_W-1:0]     smap_nxt [ARCH_REGS];
  logic [TAG_W-1:0]     amap_nxt [ARCH_REGS];
  logic [PHYS_REGS-1:0] ready;
  logic [PHYS_REGS-1:0] ready_nxt;

  logic alloc;
  logic fire;
  logic rt_we;
  logic cdb_we;

  // Rename handshake and allocation; x0 is never renamed.
  always_comb begin
    alloc    = rd_wr && (rd_idx != '0);
    rn_ready = !flush && !(alloc && fl_empty);
    fire     = rn_valid && rn_ready;
    fl_pop   = fire && alloc;
  end

  // Lookups use the pre-edge map, so rd == rs1 still sees the old tag.
  always_comb begin
    t1       = smap[rs1_idx];
    t2       = smap[rs2_idx];
    t1_ready = ready[t1] || (cdb_valid && (cdb_tag == t1));
    t2_ready = ready[t2] || (cdb_valid && (cdb_tag == t2));
    t_old    = alloc ? smap[rd_idx] : '0;
    t_new    = alloc ? fl_tag : '0;
  end

  // Architectural map: retire updates, x0 pinned to tag 0.
  always_comb begin
    rt_we    = rt_valid && (rt_rd_idx != '0);
    amap_nxt = amap;
    if (rt_we) begin
      amap_nxt[rt_rd_idx] = rt_t_new;
    end
    amap_nxt[0] = '0;
  end

  // Speculative map: flush restores from the retire-updated architectural map.
  always_comb begin
    smap_nxt = smap;
    if (flush) begin
      smap_nxt = amap_nxt;
    end else if (fl_pop) begin
      smap_nxt[rd_idx] = fl_tag;
    end
    smap_nxt[0] = '0;
  end

  // Ready bits: CDB sets, allocation clears afterwards so the clear wins.
  // A flush marks everything ready and drops the same-cycle CDB.
  always_comb begin
    cdb_we    = cdb_valid && (cdb_tag != '0);
    ready_nxt = ready;
    if (flush) begin
      ready_nxt = '1;
    end else begin
      if (cdb_we) begin
        ready_nxt[cdb_tag] = 1'b1;
      end
      if (fl_pop) begin
        ready_nxt[fl_tag] = 1'b0;
      end
    end
    ready_nxt[0] = 1'b1;
  end

  // State registers; reset gives identity maps and all tags ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        smap[i] <= TAG_W'(i);
        amap[i] <= TAG_W'(i);
      end
      ready <= '1;
    end else begin
      smap  <= smap_nxt;
      amap  <= amap_nxt;
      ready <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_map_table.sv
// Directed-vector bench for map_table: a table of per-cycle inputs with
// hand-computed combinational outputs, followed by a mid-stream reset sequence.
module tb_map_table;

  localparam int unsigned ARCH_REGS = 32;
  localparam int unsigned PHYS_REGS = 64;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned IDX_W     = 5;

  logic             clk;
  logic             reset_n;
  logic             rn_valid;
  logic             rn_ready;
  logic [IDX_W-1:0] rs1_idx, rs2_idx, rd_idx;
  logic             rd_wr;
  logic [TAG_W-1:0] t1, t2, t_new, t_old;
  logic             t1_ready, t2_ready;
  logic [TAG_W-1:0] fl_tag;
  logic             fl_empty, fl_pop;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic             rt_valid;
  logic [IDX_W-1:0] rt_rd_idx;
  logic [TAG_W-1:0] rt_t_new;
  logic             flush;

  map_table #(.ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS)) dut (
    .clk(clk), .reset_n(reset_n),
    .rn_valid(rn_valid), .rn_ready(rn_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx), .rd_wr(rd_wr),
    .t1(t1), .t2(t2), .t1_ready(t1_ready), .t2_ready(t2_ready),
    .t_new(t_new), .t_old(t_old),
    .fl_tag(fl_tag), .fl_empty(fl_empty), .fl_pop(fl_pop),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .rt_valid(rt_valid), .rt_rd_idx(rt_rd_idx), .rt_t_new(rt_t_new),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rn_valid, rs1, rs2, rd, rd_wr, fl_tag, fl_empty;
    int cdb_valid, cdb_tag, rt_valid, rt_rd, rt_tnew, flush;
    int e_ready, e_pop, e_t1, e_t1r, e_t2, e_t2r, e_tnew, e_told;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rn_valid  = 1'(v.rn_valid);
    rs1_idx   = IDX_W'(v.rs1);
    rs2_idx   = IDX_W'(v.rs2);
    rd_idx    = IDX_W'(v.rd);
    rd_wr     = 1'(v.rd_wr);
    fl_tag    = TAG_W'(v.fl_tag);
    fl_empty  = 1'(v.fl_empty);
    cdb_valid = 1'(v.cdb_valid);
    cdb_tag   = TAG_W'(v.cdb_tag);
    rt_valid  = 1'(v.rt_valid);
    rt_rd_idx = IDX_W'(v.rt_rd);
    rt_t_new  = TAG_W'(v.rt_tnew);
    flush     = 1'(v.flush);
  endtask

  task automatic compare(input int k, input vec_t v);
    string p;
    p = $sformatf("v%0d", k);
    check({p, ".rn_ready"}, int'(rn_ready), v.e_ready);
    check({p, ".fl_pop"},   int'(fl_pop),   v.e_pop);
    check({p, ".t1"},       int'(t1),       v.e_t1);
    check({p, ".t1_ready"}, int'(t1_ready), v.e_t1r);
    check({p, ".t2"},       int'(t2),       v.e_t2);
    check({p, ".t2_ready"}, int'(t2_ready), v.e_t2r);
    check({p, ".t_new"},    int'(t_new),    v.e_tnew);
    check({p, ".t_old"},    int'(t_old),    v.e_told);
    // Allocating a tag that the CDB is completing in the same cycle is illegal.
    check({p, ".alloc_cdb_conflict"},
          int'(fl_pop && cdb_valid && (cdb_tag == fl_tag)), 0);
  endtask

  // Idle vector with only the listed lookup indices changed.
  function automatic vec_t idle(input int rs1, input int rs2);
    vec_t v;
    v = '{0, rs1, rs2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 0, 0, 1, 0, 1, 0, 0};
    return v;
  endfunction

  initial begin
    //          rnv rs1 rs2 rd wr ftag emp cdbv cdbt rtv rtrd rttn fl | rdy pop t1 t1r t2 t2r tnew told
    vecs[0]  = '{0,  0,  0,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0,  0, 1,  0, 1,  0,  0};
    vecs[1]  = '{1,  3,  7,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0,  3, 1,  7, 1,  0,  0};
    vecs[2]  = '{1,  5,  0,  5, 1, 40,  0,  0,   0,   0,  0,   0,  0,  1,  1,  5, 1,  0, 1, 40,  5};
    vecs[3]  = '{1,  5,  3,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0, 40, 0,  3, 1,  0,  0};
    vecs[4]  = '{1,  5,  0,  0, 0,  0,  0,  1,  40,   0,  0,   0,  0,  1,  0, 40, 1,  0, 1,  0,  0};
    vecs[5]  = '{1,  5,  0,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0, 40, 1,  0, 1,  0,  0};
    vecs[6]  = '{1,  9,  0,  9, 1, 41,  1,  0,   0,   0,  0,   0,  0,  0,  0,  9, 1,  0, 1, 41,  9};
    vecs[7]  = '{1,  9,  0,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0,  9, 1,  0, 1,  0,  0};
    vecs[8]  = '{1,  0,  0,  0, 1, 41,  1,  0,   0,   0,  0,   0,  0,  1,  0,  0, 1,  0, 1,  0,  0};
    vecs[9]  = '{1,  5,  0,  5, 1, 41,  0,  0,   0,   0,  0,   0,  0,  1,  1, 40, 1,  0, 1, 41, 40};
    vecs[10] = '{0,  5,  0,  0, 0,  0,  0,  0,   0,   1,  5,  40,  0,  1,  0, 41, 0,  0, 1,  0,  0};
    vecs[11] = '{1,  5,  0,  6, 1, 42,  0,  0,   0,   1,  5,  41,  1,  0,  0, 41, 0,  0, 1, 42,  6};
    vecs[12] = '{1,  5,  6,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0, 41, 1,  6, 1,  0,  0};
    vecs[13] = '{1, 12,  0,  9, 1, 12,  0,  0,   0,   0,  0,   0,  0,  1,  1, 12, 1,  0, 1, 12,  9};
    vecs[14] = '{1, 12,  9,  0, 0,  0,  0,  0,   0,   0,  0,   0,  0,  1,  0, 12, 0, 12, 0,  0,  0};
    vecs[15] = '{0,  3,  0,  0, 0,  0,  0,  0,   0,   1,  3,  50,  0,  1,  0,  3, 1,  0, 1,  0,  0};

    reset_n = 1'b0;
    drive(idle(0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #2;
      compare(k, vecs[k]);
    end

    // Mid-stream reset: identity maps and ready bits must appear immediately.
    @(negedge clk);
    drive(idle(9, 12));
    #1;
    reset_n = 1'b0;
    #1;
    check("rst.t1_x9", int'(t1), 9);
    check("rst.t2_x12", int'(t2), 12);
    check("rst.t2_ready_x12", int'(t2_ready), 1);
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      rs1_idx = IDX_W'(i);
      #1;
      check($sformatf("rst.smap[%0d]", i), int'(t1), i);
      check($sformatf("rst.ready[%0d]", i), int'(t1_ready), 1);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Flush after reset exposes the architectural map: x3 must be back to 3.
    @(negedge clk);
    drive(idle(0, 0));
    flush = 1'b1;
    #2;
    check("flush.rn_ready", int'(rn_ready), 0);
    @(negedge clk);
    drive(idle(3, 5));
    #2;
    check("amap.x3", int'(t1), 3);
    check("amap.x5", int'(t2), 5);
    check("amap.x3_ready", int'(t1_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  // Safety bound in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
